warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Sequences instruction execution for up to NUM_WARPS warps sharing the single fetch port, decoder, ALU and LSU of a core. Selects warps round-robin, fetches one instruction per turn, presents it to the decoder, then uses the decoded control bits to execute, wait on memory, write back, and advance or redirect the warp's PC. Sits between instruction memory and the decoder/execute datapath; raises done when every launched warp has retired a finish instruction.

## Interface
- NUM_WARPS, 4: warp count (≥2, power of two)
- PC_WIDTH, 8: instruction word-address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  launch pulse; honoured only in IDLE or DONE
- warp_enable  in  NUM_WARPS  warps to launch, sampled with start
- done  out  1  all launched warps finished
- instr_mem_read_valid  out  1  fetch request
- instr_mem_read_address  out  PC_WIDTH  PC of current warp
- instr_mem_read_ready  in  1  fetch data valid this cycle
- instr_mem_read_data  in  32  fetched instruction
- instruction  out  32  registered instruction to decoder
- current_warp  out  $clog2(NUM_WARPS)  warp owning the datapath
- decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable, decoded_branch, decoded_finish  in  1 each  from decoder
- decoded_immediate  in  32  from decoder
- branch_taken  in  1  ALU compare result, valid in EXECUTE
- lsu_request_valid  out  1  memory access request
- lsu_done  in  1  memory access complete
- reg_write_strobe  out  1  one-cycle register-file write pulse

## Operation
- State per warp: pc[PC_WIDTH], active bit. Shared: state, rr pointer, instruction register.
- FSM: IDLE, SELECT, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, DONE.
- IDLE/DONE + start: active ← warp_enable, all pc ← 0, rr ← NUM_WARPS−1, done ← 0, → SELECT. start in any other state ignored.
- SELECT: pick first active warp strictly after rr (mod NUM_WARPS), set current_warp and rr to it, → FETCH. No active warps → DONE.
- FETCH: instr_mem_read_valid=1, address=pc[current_warp]; held until ready. On ready cycle latch data into instruction, → DECODE.
- DECODE: decoder output stable. decoded_finish → clear active[current_warp], no PC change, → SELECT. Else → EXECUTE.
- EXECUTE: mem read/write enable → MEM_WAIT; else → WRITEBACK. Branch decision captured here: taken = decoded_branch & branch_taken.
- MEM_WAIT: lsu_request_valid=1 until lsu_done sampled high (done in same cycle as request allowed), → WRITEBACK.
- WRITEBACK: reg_write_strobe = decoded_reg_write_enable for exactly this cycle. pc ← taken ? pc + decoded_immediate[PC_WIDTH+1:2] : pc + 1, modulo 2^PC_WIDTH (byte offset → word offset, truncated). → SELECT.
- DONE: done=1, holds until start.
- Only the current warp's pc/active change; other warps untouched.

## Timing
- Reset (async): state IDLE, all pc 0, active 0, rr NUM_WARPS−1, instruction 0, current_warp 0; done, instr_mem_read_valid, lsu_request_valid, reg_write_strobe all 0; address 0.
- Reset mid-operation abandons outstanding fetch/LSU request immediately; no strobe issued.
- ALU instruction, ready immediate: 5 cycles SELECT→WRITEBACK; next warp's SELECT follows.
- Each extra fetch-stall cycle or LSU cycle adds one cycle.
- Finish instruction: 3 cycles (SELECT, FETCH, DECODE).
- done asserts the cycle after SELECT finds no active warp.
- start with warp_enable=0: SELECT then DONE (done high two cycles after start).
- ready/lsu_done asserted outside FETCH/MEM_WAIT: ignored.

## Test plan
- Reset released, no start -> all outputs 0 indefinitely, state IDLE.
- warp_enable=4'b0101, memory returns ADD every fetch with ready immediate -> current_warp sequence 0,2,0,2; reg_write_strobe every 5 cycles; pc of warps 0,2 increment by 1 per turn, warps 1,3 stay 0.
- Single warp, branch at pc=3 with immediate 0xFFFFFFF4, branch_taken=1 -> next fetch address 0; with branch_taken=0 -> 4.
- Load with lsu_done delayed 4 cycles -> lsu_request_valid high 4 cycles, strobe one cycle after lsu_done; store -> no strobe.
- Two warps; warp 1 hits finish, warp 0 continues; then warp 0 finishes -> fetch only warp 0 after warp 1 finish, done rises, start during execution ignored.
- reset asserted during MEM_WAIT -> lsu_request_valid drops asynchronously, all pc 0, IDLE.

Source files
------------

// File: rtl/warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : warp_scheduler                                               |
// | Description : Round-robin warp sequencer for a core whose fetch port,       |
// |               decoder, ALU and LSU are shared by all warps. Each turn       |
// |               runs one instruction of one warp through SELECT, FETCH,       |
// |               DECODE, EXECUTE, optional MEM_WAIT and WRITEBACK.             |
// | Ports       : clk/reset            - clock, async active-high reset         |
// |               start/warp_enable    - launch request and warp mask           |
// |               done                 - every launched warp has finished       |
// |               instr_mem_read_*     - instruction fetch handshake            |
// |               instruction          - registered instruction to decoder      |
// |               current_warp         - warp owning the datapath               |
// |               decoded_*            - control bits back from the decoder     |
// |               branch_taken         - ALU compare result (EXECUTE)           |
// |               lsu_request_valid/lsu_done - memory access handshake          |
// |               reg_write_strobe     - one-cycle register-file write pulse    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int PC_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_WARPS-1:0]         warp_enable,
  output logic                         done,
  output logic                         instr_mem_read_valid,
  output logic [PC_WIDTH-1:0]          instr_mem_read_address,
  input  logic                         instr_mem_read_ready,
  input  logic [31:0]                  instr_mem_read_data,
  output logic [31:0]                  instruction,
  output logic [$clog2(NUM_WARPS)-1:0] current_warp,
  input  logic                         decoded_reg_write_enable,
  input  logic                         decoded_mem_read_enable,
  input  logic                         decoded_mem_write_enable,
  input  logic                         decoded_branch,
  input  logic                         decoded_finish,
  input  logic [31:0]                  decoded_immediate,
  input  logic                         branch_taken,
  output logic                         lsu_request_valid,
  input  logic                         lsu_done,
  output logic                         reg_write_strobe
);

  localparam int WARP_W = $clog2(NUM_WARPS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM_WAIT  = 3'd5,
    S_WRITEBACK = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]  active_q;
  logic [WARP_W-1:0]     rr_q;
  logic [WARP_W-1:0]     current_warp_q;
  logic [31:0]           instruction_q;
  logic                  taken_q;

  logic                  sel_found;
  logic [WARP_W-1:0]     sel_warp;
  logic [WARP_W-1:0]     sel_cand;
  logic [PC_WIDTH-1:0]   branch_offset;
  logic                  unused_imm;

  // Byte offset to word offset; upper bits beyond the PC width are dropped.
  assign branch_offset = decoded_immediate[PC_WIDTH+1:2];
  assign unused_imm    = ^decoded_immediate;

  // Search order starts just after the last-served warp; k = NUM_WARPS wraps
  // back to rr itself, so a lone active warp is re-selected.
  always_comb begin
    sel_found = 1'b0;
    sel_warp  = rr_q;
    sel_cand  = rr_q;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      sel_cand = rr_q + WARP_W'(k);
      if (!sel_found && active_q[sel_cand]) begin
        sel_found = 1'b1;
        sel_warp  = sel_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    done                 = 1'b0;
    instr_mem_read_valid = 1'b0;
    lsu_request_valid    = 1'b0;
    reg_write_strobe     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        state_d = sel_found ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        instr_mem_read_valid = 1'b1;
        if (instr_mem_read_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = decoded_finish ? S_SELECT : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = (decoded_mem_read_enable || decoded_mem_write_enable) ? S_MEM_WAIT : S_WRITEBACK;
      end
      S_MEM_WAIT: begin
        lsu_request_valid = 1'b1;
        if (lsu_done) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        reg_write_strobe = decoded_reg_write_enable;
        state_d          = S_SELECT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
      active_q       <= '0;
      rr_q           <= WARP_W'(NUM_WARPS - 1);
      current_warp_q <= '0;
      instruction_q  <= '0;
      taken_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
            active_q <= warp_enable;
            rr_q     <= WARP_W'(NUM_WARPS - 1);
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            current_warp_q <= sel_warp;
            rr_q           <= sel_warp;
          end
        end
        S_FETCH: begin
          if (instr_mem_read_ready) instruction_q <= instr_mem_read_data;
        end
        S_DECODE: begin
          if (decoded_finish) active_q[current_warp_q] <= 1'b0;
        end
        S_EXECUTE: begin
          taken_q <= decoded_branch & branch_taken;
        end
        S_WRITEBACK: begin
          pc_q[current_warp_q] <= taken_q ? pc_q[current_warp_q] + branch_offset
                                          : pc_q[current_warp_q] + PC_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign instr_mem_read_address = pc_q[current_warp_q];
  assign instruction            = instruction_q;
  assign current_warp           = current_warp_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_warp_scheduler                                            |
// | Description : Directed self-checking bench for warp_scheduler with a tiny  |
// |               decoder model, per-warp program tables and an LSU model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_warp_scheduler;

  localparam logic [31:0] I_ADD    = 32'h1000_0000;
  localparam logic [31:0] I_LOAD   = 32'h2000_0000;
  localparam logic [31:0] I_STORE  = 32'h3000_0000;
  localparam logic [31:0] I_BRNEG  = 32'h4000_FFF4;
  localparam logic [31:0] I_FINISH = 32'h5000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  warp_enable = 4'b0;
  logic        done;
  logic        instr_mem_read_valid;
  logic [7:0]  instr_mem_read_address;
  logic        instr_mem_read_ready;
  logic [31:0] instr_mem_read_data;
  logic [31:0] instruction;
  logic [1:0]  current_warp;
  logic        decoded_reg_write_enable;
  logic        decoded_mem_read_enable;
  logic        decoded_mem_write_enable;
  logic        decoded_branch;
  logic        decoded_finish;
  logic [31:0] decoded_immediate;
  logic        branch_taken = 1'b0;
  logic        lsu_request_valid;
  logic        lsu_done;
  logic        reg_write_strobe;

  int checks = 0;
  int errors = 0;
  int lsu_lat = 1;
  int lsu_cnt = 0;
  logic [31:0] prog [4][16];
  logic [3:0]  op;

  warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .warp_enable              (warp_enable),
    .done                     (done),
    .instr_mem_read_valid     (instr_mem_read_valid),
    .instr_mem_read_address   (instr_mem_read_address),
    .instr_mem_read_ready     (instr_mem_read_ready),
    .instr_mem_read_data      (instr_mem_read_data),
    .instruction              (instruction),
    .current_warp             (current_warp),
    .decoded_reg_write_enable (decoded_reg_write_enable),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .decoded_branch           (decoded_branch),
    .decoded_finish           (decoded_finish),
    .decoded_immediate        (decoded_immediate),
    .branch_taken             (branch_taken),
    .lsu_request_valid        (lsu_request_valid),
    .lsu_done                 (lsu_done),
    .reg_write_strobe         (reg_write_strobe)
  );

  always #5 clk = ~clk;

  // Decoder model: opcode in [31:28], sign-extended 16-bit immediate.
  assign op                       = instruction[31:28];
  assign decoded_reg_write_enable = (op == 4'h1) || (op == 4'h2);
  assign decoded_mem_read_enable  = (op == 4'h2);
  assign decoded_mem_write_enable = (op == 4'h3);
  assign decoded_branch           = (op == 4'h4);
  assign decoded_finish           = (op == 4'h5);
  assign decoded_immediate        = {{16{instruction[15]}}, instruction[15:0]};

  assign instr_mem_read_ready = 1'b1;
  assign instr_mem_read_data  = prog[current_warp][instr_mem_read_address[3:0]];

  // LSU model: completes on the lsu_lat-th cycle of a continuous request.
  always @(posedge clk) lsu_cnt <= lsu_request_valid ? lsu_cnt + 1 : 0;
  assign lsu_done = lsu_request_valid && (lsu_cnt == lsu_lat - 1);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_prog(input logic [31:0] word);
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 16; a++) prog[w][a] = word;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_prog(I_ADD);
    #1;
    // ---- Reset, no start: all outputs stay low.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("idle_done", done, 0);
      check("idle_fetch", instr_mem_read_valid, 0);
      check("idle_lsu", lsu_request_valid, 0);
      check("idle_strobe", reg_write_strobe, 0);
      check("idle_addr", instr_mem_read_address, 0);
    end
    check("idle_instr", instruction, 0);
    check("idle_warp", current_warp, 0);

    // ---- Warps 0 and 2, ADD everywhere: 5-cycle turns alternating 0,2.
    warp_enable = 4'b0101;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      start = 1'b0;
      check("rr_strobe", reg_write_strobe, (i % 5 == 0));
      check("rr_fetch", instr_mem_read_valid, (i % 5 == 2));
      if (i % 5 == 2) begin
        check("rr_warp", current_warp, ((i / 5) % 2 == 1) ? 2 : 0);
        check("rr_addr", instr_mem_read_address, (i / 5) / 2);
      end
    end

    // ---- Branch at pc 3 with -12 bytes: taken -> 0, not taken -> 4.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      fill_prog(I_ADD);
      prog[0][3] = I_BRNEG;
      branch_taken = (pass == 0);
      warp_enable = 4'b0001;
      start = 1'b1;
      for (int i = 1; i <= 22; i++) begin
        cyc();
        start = 1'b0;
        check("br_strobe", reg_write_strobe, (i == 5) || (i == 10) || (i == 15));
        if (i == 17) check("br_addr_pre", instr_mem_read_address, 3);
        if (i == 22) begin
          check("br_fetch", instr_mem_read_valid, 1);
          check(pass == 0 ? "br_taken_addr" : "br_nt_addr", instr_mem_read_address, pass == 0 ? 0 : 4);
        end
      end
    end
    branch_taken = 1'b0;

    // ---- Load with 4-cycle LSU, then store (no strobe).
    do_reset();
    fill_prog(I_ADD);
    prog[0][0] = I_LOAD;
    prog[0][1] = I_STORE;
    lsu_lat = 4;
    warp_enable = 4'b0001;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      start = 1'b0;
      check("ls_lsu", lsu_request_valid, ((i >= 5) && (i <= 8)) || ((i >= 14) && (i <= 17)));
      check("ls_strobe", reg_write_strobe, (i == 9));
      if (i == 20) check("ls_next_addr", instr_mem_read_address, 2);
    end

    // ---- Warp 1 finishes first, warp 0 later; a mid-run start is ignored.
    do_reset();
    fill_prog(I_ADD);
    prog[1][0] = I_FINISH;
    prog[0][2] = I_FINISH;
    warp_enable = 4'b0011;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      start = 1'b0;
      check("fin_done", done, (i >= 18));
      check("fin_fetch", instr_mem_read_valid, (i == 2) || (i == 7) || (i == 10) || (i == 15));
      if (i == 7) check("fin_w1_warp", current_warp, 1);
      if (i == 10) begin
        check("fin_w0_warp", current_warp, 0);
        check("fin_w0_addr", instr_mem_read_address, 1);
        warp_enable = 4'b1111;
        start = 1'b1;
      end
      if (i == 15) check("fin_w0_last", instr_mem_read_address, 2);
      if (i == 16) check("fin_strobe", reg_write_strobe, 0);
    end
    // start with no warps from DONE: SELECT then DONE.
    warp_enable = 4'b0000;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("empty_done_low", done, 0);
    cyc();
    check("empty_done_high", done, 1);
    cyc();
    check("empty_done_hold", done, 1);

    // ---- Reset during MEM_WAIT of warp 1 (pc 1).
    do_reset();
    fill_prog(I_ADD);
    prog[1][1] = I_LOAD;
    lsu_lat = 10;
    warp_enable = 4'b0010;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      start = 1'b0;
    end
    check("mw_lsu_before", lsu_request_valid, 1);
    check("mw_addr_before", instr_mem_read_address, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mw_lsu_async", lsu_request_valid, 0);
    check("mw_addr_reset", instr_mem_read_address, 0);
    check("mw_warp_reset", current_warp, 0);
    check("mw_instr_reset", instruction, 0);
    check("mw_strobe_reset", reg_write_strobe, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mw_idle_lsu", lsu_request_valid, 0);
      check("mw_idle_fetch", instr_mem_read_valid, 0);
      check("mw_idle_done", done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
